dcache: RTL and testbench

Data-cache responder on the core's `dcache_*` port: accepts load and store requests from the core, answers with `dcache_rvalid`/`dcache_wvalid`, and sits between the core and a word-wide backing memory. Organization:

- Direct-mapped, write-through, no-write-allocate.
- Read misses refill a whole line from backing memory before the core is answered.
- Write hits update the cached bytes and always write through.

---
 rtl/dcache.sv | 248 ++++++++++++++++++++++++
 tb/tb_dcache.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// -----------------------------------------------------------------------------
// dcache
// Direct-mapped, write-through, no-write-allocate data cache placed between
// the core's dcache_* port and a word-wide backing memory.
//   * Read hit   : answered from the data array one cycle after acceptance.
//   * Read miss  : the whole line is refilled word by word (words 0..WORDS-1)
//                  before the core is answered.
//   * Write      : always written through. On a hit, the enabled bytes are
//                  also merged into the cached word. A miss leaves the cache
//                  unchanged.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   dcache_addr          byte address from the core (bits [1:0] ignored)
//   dcache_rreq/_wreq    level requests, held by the core until its response
//   dcache_wdata         store data
//   dcache_byte_enable   store lanes; bit i enables byte i of wdata
//   dcache_rdata         load data, valid while dcache_rvalid
//   dcache_rvalid        one-cycle load-complete pulse
//   dcache_wvalid        one-cycle store-complete pulse
//   mem_addr             word-aligned backing address
//   mem_rreq/_wreq       backing requests, held until mem_rvalid/mem_wvalid
//   mem_wdata            backing write data
//   mem_byte_enable      backing write lanes
//   mem_rdata            backing read data
//   mem_rvalid/_wvalid   backing completion pulses
// -----------------------------------------------------------------------------
module dcache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_rreq,
  input  logic        dcache_wreq,
  input  logic [31:0] dcache_wdata,
  input  logic [3:0]  dcache_byte_enable,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rvalid,
  output logic        dcache_wvalid,
  output logic [31:0] mem_addr,
  output logic        mem_rreq,
  output logic        mem_wreq,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_wvalid
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFILL,
    S_RESP_R,
    S_WRITE,
    S_RESP_W,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  // Captured request (word address only; the byte offset is never used).
  logic [29:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [OFF_W-1:0] word_q;

  // Line storage.
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS];

  // Field split of the incoming address (used only while IDLE).
  logic [OFF_W-1:0] in_off;
  logic [IDX_W-1:0] in_idx;
  logic [TAG_W-1:0] in_tag;
  logic             in_hit;

  assign in_off = dcache_addr[OFF_W+1:2];
  assign in_idx = dcache_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign in_tag = dcache_addr[31:OFF_W+IDX_W+2];
  assign in_hit = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

  // Field split of the captured address.
  logic [OFF_W-1:0] cap_off;
  logic [IDX_W-1:0] cap_idx;
  logic [TAG_W-1:0] cap_tag;

  assign cap_off = addr_q[OFF_W-1:0];
  assign cap_idx = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign cap_tag = addr_q[29:OFF_W+IDX_W];

  // The byte offset of the core address carries no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dcache_addr[1:0];

  // Acceptance and refill progress, shared by the control and array processes.
  logic accept_w;
  logic accept_r;
  logic refill_beat;
  logic refill_last;

  assign accept_w    = (state_q == S_IDLE) && dcache_wreq;
  assign accept_r    = (state_q == S_IDLE) && !dcache_wreq && dcache_rreq;
  assign refill_beat = (state_q == S_REFILL) && mem_rvalid;
  assign refill_last = refill_beat && (word_q == OFF_W'(WORDS - 1));

  // ---------------------------------------------------------------------------
  // State register and control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      valid_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;

      if (accept_w || accept_r) begin
        addr_q  <= dcache_addr[31:2];
        wdata_q <= dcache_wdata;
        be_q    <= dcache_byte_enable;
      end

      // A refill overwrites the line word by word; drop its valid bit up
      // front so a partially refilled line is never reported as a hit.
      if (accept_r && !in_hit) begin
        valid_q[in_idx] <= 1'b0;
      end

      if (refill_beat) begin
        word_q <= word_q + OFF_W'(1);  // wraps to 0 after the last word
      end

      if (refill_last) begin
        valid_q[cap_idx] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag and data arrays
  // ---------------------------------------------------------------------------
  // NOTE: the tag and data arrays are deliberately not reset; only the valid
  // bits are. Stale contents are unreachable while valid is clear, and leaving
  // the arrays out of reset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill_beat) begin
        data_q[{cap_idx, word_q}] <= mem_rdata;
      end
      if (refill_last) begin
        tag_q[cap_idx] <= cap_tag;
      end
      // Write hit: merge the enabled bytes when the store is accepted.
      if (accept_w && in_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (dcache_byte_enable[b]) begin
            data_q[{in_idx, in_off}][8*b +: 8] <= dcache_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks assign every output a default first, so no
  // path through the case statement can leave a value unassigned and infer
  // a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (dcache_wreq) begin
          state_d = S_WRITE;
        end else if (dcache_rreq) begin
          state_d = in_hit ? S_RESP_R : S_REFILL;
        end
      end
      S_REFILL: begin
        if (refill_last) begin
          state_d = S_RESP_R;
        end
      end
      S_RESP_R: state_d = S_DRAIN;
      S_WRITE: begin
        if (mem_wvalid) begin
          state_d = S_RESP_W;
        end
      end
      S_RESP_W: state_d = S_DRAIN;
      S_DRAIN: begin
        // Hold here until the core lets go, so a still-held request is not
        // taken as a new one.
        if (!dcache_rreq && !dcache_wreq) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the state register and captured request
  // ---------------------------------------------------------------------------
  always_comb begin
    dcache_rdata    = '0;
    dcache_rvalid   = 1'b0;
    dcache_wvalid   = 1'b0;
    mem_addr        = '0;
    mem_rreq        = 1'b0;
    mem_wreq        = 1'b0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    unique case (state_q)
      S_REFILL: begin
        mem_rreq = 1'b1;
        mem_addr = {addr_q[29:OFF_W], word_q, 2'b00};
      end
      S_RESP_R: begin
        dcache_rvalid = 1'b1;
        dcache_rdata  = data_q[{cap_idx, cap_off}];
      end
      S_WRITE: begin
        mem_wreq        = 1'b1;
        mem_addr        = {addr_q, 2'b00};
        mem_wdata       = wdata_q;
        mem_byte_enable = be_q;
      end
      S_RESP_W: dcache_wvalid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// -----------------------------------------------------------------------------
// tb_dcache
// Self-checking bench for dcache. A behavioural backing memory answers
// mem_rreq/mem_wreq after a programmable number of cycles and logs every
// completed transfer. Directed vectors (table below) drive one core request
// each and compare load data, latency, response-pulse count and the backing
// traffic against hand-computed values; hand-written sequences cover the
// slow-memory refill and reset in the middle of a refill.
// -----------------------------------------------------------------------------
module tb_dcache;

  logic        clk;
  logic        rst;
  logic [31:0] dcache_addr;
  logic        dcache_rreq;
  logic        dcache_wreq;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_byte_enable;
  logic [31:0] dcache_rdata;
  logic        dcache_rvalid;
  logic        dcache_wvalid;
  logic [31:0] mem_addr;
  logic        mem_rreq;
  logic        mem_wreq;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wvalid;

  dcache #(.LINES(16), .WORDS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .dcache_addr        (dcache_addr),
    .dcache_rreq        (dcache_rreq),
    .dcache_wreq        (dcache_wreq),
    .dcache_wdata       (dcache_wdata),
    .dcache_byte_enable (dcache_byte_enable),
    .dcache_rdata       (dcache_rdata),
    .dcache_rvalid      (dcache_rvalid),
    .dcache_wvalid      (dcache_wvalid),
    .mem_addr           (mem_addr),
    .mem_rreq           (mem_rreq),
    .mem_wreq           (mem_wreq),
    .mem_wdata          (mem_wdata),
    .mem_byte_enable    (mem_byte_enable),
    .mem_rdata          (mem_rdata),
    .mem_rvalid         (mem_rvalid),
    .mem_wvalid         (mem_wvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Backing memory model
  // ---------------------------------------------------------------------------
  logic [31:0] bmem [4096];
  int          rd_delay = 0;
  int          wr_delay = 0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [3:0]  wr_be_log[$];

  initial begin
    int rcnt;
    int wcnt;
    rcnt = 0;
    wcnt = 0;
    mem_rvalid = 1'b0;
    mem_wvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_wvalid = 1'b0;
      mem_rdata  = '0;
      if (rst) begin
        rcnt = 0;
        wcnt = 0;
      end else begin
        if (mem_rreq) begin
          if (rcnt >= rd_delay) begin
            mem_rvalid = 1'b1;
            mem_rdata  = bmem[mem_addr[13:2]];
            rd_log.push_back(mem_addr);
            rcnt = 0;
          end else begin
            rcnt++;
          end
        end
        if (mem_wreq) begin
          if (wcnt >= wr_delay) begin
            mem_wvalid = 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (mem_byte_enable[b]) bmem[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
            wr_be_log.push_back(mem_byte_enable);
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One core transaction: raise the request, wait (bounded) for the response,
  // keep the request held two more cycles, release it, then watch a few more
  // cycles. Every response pulse seen during the whole window is counted.
  // ---------------------------------------------------------------------------
  task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output int lat,
                      output int pulses);
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_be_log.delete();
    rd     = '0;
    lat    = -1;
    pulses = 0;
    @(negedge clk);
    dcache_addr        = addr;
    dcache_wdata       = wd;
    dcache_byte_enable = be;
    if (wr) dcache_wreq = 1'b1;
    else    dcache_rreq = 1'b1;
    for (int c = 1; c <= 400 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (dcache_rvalid || dcache_wvalid) begin
        lat = c;
        pulses++;
        rd = dcache_rdata;
      end
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      if (dcache_rvalid || dcache_wvalid) pulses++;
    end
    @(negedge clk);
    dcache_rreq = 1'b0;
    dcache_wreq = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (dcache_rvalid || dcache_wvalid) pulses++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " dcache_rdata"},    dcache_rdata, 32'h0);
    check({tag, " dcache_rvalid"},   {31'b0, dcache_rvalid}, 32'h0);
    check({tag, " dcache_wvalid"},   {31'b0, dcache_wvalid}, 32'h0);
    check({tag, " mem_addr"},        mem_addr, 32'h0);
    check({tag, " mem_rreq"},        {31'b0, mem_rreq}, 32'h0);
    check({tag, " mem_wreq"},        {31'b0, mem_wreq}, 32'h0);
    check({tag, " mem_wdata"},       mem_wdata, 32'h0);
    check({tag, " mem_byte_enable"}, {28'b0, mem_byte_enable}, 32'h0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    int          exp_nrd;
    logic [31:0] exp_rd0;
    int          exp_nwr;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  initial begin
    logic [31:0] rd;
    int          lat;
    int          pulses;
    bit          seen;

    // Backing contents: 0xA0 + word-in-line everywhere, 0xB0 + word in 0x500.
    for (int i = 0; i < 4096; i++) bmem[i] = 32'hA0 + 32'(i % 4);
    for (int w = 0; w < 4; w++) bmem[32'h140 + w] = 32'hB0 + 32'(w);

    //            wr    addr          wdata         be       rdata         nrd rd0          nwr lat
    vecs[0]  = '{1'b0, 32'h0000_0104, 32'h0,        4'b0000, 32'h0000_00A1, 4, 32'h0000_0100, 0, 5};  // cold miss
    vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,        4'b0000, 32'h0000_00A1, 0, 32'h0,         0, 1};  // hit
    vecs[2]  = '{1'b1, 32'h0000_0104, 32'hDEADBEEF, 4'b0011, 32'h0,         0, 32'h0,         1, 2};  // write hit
    vecs[3]  = '{1'b0, 32'h0000_0104, 32'h0,        4'b0000, 32'h0000_BEEF, 0, 32'h0,         0, 1};  // merged
    vecs[4]  = '{1'b1, 32'h0000_2000, 32'h12345678, 4'b1111, 32'h0,         0, 32'h0,         1, 2};  // write miss
    vecs[5]  = '{1'b0, 32'h0000_2000, 32'h0,        4'b0000, 32'h1234_5678, 4, 32'h0000_2000, 0, 5};  // no allocate
    vecs[6]  = '{1'b0, 32'h0000_0108, 32'h0,        4'b0000, 32'h0000_00A2, 4, 32'h0000_0100, 0, 5};  // evicted by 0x2000
    vecs[7]  = '{1'b0, 32'h0000_0504, 32'h0,        4'b0000, 32'h0000_00B1, 4, 32'h0000_0500, 0, 5};  // conflict
    vecs[8]  = '{1'b0, 32'h0000_0104, 32'h0,        4'b0000, 32'h0000_BEEF, 4, 32'h0000_0100, 0, 5};  // refill again
    vecs[9]  = '{1'b1, 32'h0000_030C, 32'hCAFEF00D, 4'b1000, 32'h0,         0, 32'h0,         1, 2};  // miss, same index
    vecs[10] = '{1'b0, 32'h0000_0104, 32'h0,        4'b0000, 32'h0000_BEEF, 0, 32'h0,         0, 1};  // line kept
    vecs[11] = '{1'b0, 32'h0000_030C, 32'h0,        4'b0000, 32'hCA00_00A3, 4, 32'h0000_0300, 0, 5};
    vecs[12] = '{1'b1, 32'h0000_0308, 32'h11223344, 4'b0100, 32'h0,         0, 32'h0,         1, 2};
    vecs[13] = '{1'b0, 32'h0000_0308, 32'h0,        4'b0000, 32'h0022_00A2, 0, 32'h0,         0, 1};
    vecs[14] = '{1'b0, 32'h0000_03F4, 32'h0,        4'b0000, 32'h0000_00A1, 4, 32'h0000_03F0, 0, 5};  // last index
    vecs[15] = '{1'b0, 32'h0000_03F4, 32'h0,        4'b0000, 32'h0000_00A1, 0, 32'h0,         0, 1};
    vecs[16] = '{1'b1, 32'h0000_03F0, 32'hAABBCCDD, 4'b1010, 32'h0,         0, 32'h0,         1, 2};
    vecs[17] = '{1'b0, 32'h0000_03F0, 32'h0,        4'b0000, 32'hAA00_CCA0, 0, 32'h0,         0, 1};

    rst                = 1'b1;
    dcache_addr        = '0;
    dcache_rreq        = 1'b0;
    dcache_wreq        = 1'b0;
    dcache_wdata       = '0;
    dcache_byte_enable = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < NVEC; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      xact(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, rd, lat, pulses);
      check({tag, " rdata"},   rd, vecs[v].exp_rdata);
      check({tag, " latency"}, lat, vecs[v].exp_lat);
      check({tag, " pulses"},  pulses, 1);
      check({tag, " mem reads"},  rd_log.size(), vecs[v].exp_nrd);
      check({tag, " mem writes"}, wr_addr_log.size(), vecs[v].exp_nwr);
      if (vecs[v].exp_nrd == 4 && rd_log.size() == 4) begin
        for (int w = 0; w < 4; w++)
          check($sformatf("%s refill addr %0d", tag, w), rd_log[w], vecs[v].exp_rd0 + 32'(4 * w));
      end
      if (vecs[v].exp_nwr == 1 && wr_addr_log.size() == 1) begin
        check({tag, " wr addr"}, wr_addr_log[0], vecs[v].addr & 32'hFFFF_FFFC);
        check({tag, " wr data"}, wr_data_log[0], vecs[v].wdata);
        check({tag, " wr be"},   {28'b0, wr_be_log[0]}, {28'b0, vecs[v].be});
      end
    end
    check_idle_outputs("idle");

    // ---------------- slow backing memory ----------------
    rd_delay = 5;
    xact(1'b0, 32'h0000_1048, 32'h0, 4'b0, rd, lat, pulses);
    check("slow refill rdata",   rd, 32'h0000_00A2);
    check("slow refill latency", lat, 25);
    check("slow refill pulses",  pulses, 1);
    check("slow refill reads",   rd_log.size(), 4);
    rd_delay = 0;

    wr_delay = 3;
    xact(1'b1, 32'h0000_1044, 32'h55667788, 4'b1111, rd, lat, pulses);
    check("slow write latency", lat, 5);
    check("slow write pulses",  pulses, 1);
    check("slow write count",   wr_addr_log.size(), 1);
    wr_delay = 0;
    xact(1'b0, 32'h0000_1044, 32'h0, 4'b0, rd, lat, pulses);
    check("after slow write rdata", rd, 32'h5566_7788);
    check("after slow write lat",   lat, 1);

    // ---------------- reset during refill word 2 ----------------
    rd_delay = 3;
    @(negedge clk);
    dcache_addr = 32'h0000_2204;
    dcache_rreq = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (mem_rreq && mem_addr == 32'h0000_2208) seen = 1'b1;
    end
    check("reached refill word 2", {31'b0, seen}, 32'h1);
    @(negedge clk);
    rst         = 1'b1;
    dcache_rreq = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("mid-refill reset");
    @(negedge clk);
    rst      = 1'b0;
    rd_delay = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (dcache_rvalid) check("no response after reset", 32'h1, 32'h0);
    end

    xact(1'b0, 32'h0000_2204, 32'h0, 4'b0, rd, lat, pulses);
    check("post-reset rdata",  rd, 32'h0000_00A1);
    check("post-reset reads",  rd_log.size(), 4);
    check("post-reset pulses", pulses, 1);
    // 0x3F4 was cached before reset; valid bits must have been cleared.
    xact(1'b0, 32'h0000_03F4, 32'h0, 4'b0, rd, lat, pulses);
    check("valid cleared reads", rd_log.size(), 4);
    check("valid cleared rdata", rd, 32'h0000_00A1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
